// File: rtl/pipelined_carry_adder.sv
// pipelined_carry_adder: WIDTH-bit add/subtract split into STAGES carry-pipelined chunks with valid/ready handshakes.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid, in_ready         operand beat handshake (in_ready = !stall)
//   a, b, cin, sub             operands, carry-in (add only), 1 = subtract
//   out_valid, out_ready       result beat handshake
//   sum, cout                  result and carry out of the MSB (1 = no borrow on subtract)
//   ovf                        signed overflow, present only when PIPE_ADDER_OVF_EN is defined
module pipelined_carry_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_ADDER_OVF_EN
   ,output logic             ovf
`endif
);
    localparam int CW = WIDTH / STAGES;

    logic             stall;
    logic [WIDTH-1:0] a_q, b_q;
    logic             c_q, v_q;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // Operand capture: b is inverted and the carry forced to 1 here so the chunk stages only ever add.
    always_ff @(posedge clk) begin
        if (!rst_n) v_q <= 1'b0;
        else if (!stall) v_q <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            a_q <= a;
            b_q <= sub ? ~b : b;
            c_q <= sub | cin;
        end
    end

    // Stage s adds chunk s. Only the operand chunks still to be added travel forward (skew),
    // and finished result chunks accumulate in lo until the last stage (de-skew).
    for (genvar s = 0; s < STAGES; s++) begin : g_st
        localparam int HW = WIDTH - s * CW;
        logic [HW-1:0]         ua, ub;
        logic                  c, v;
        logic [CW:0]           part;
        logic [(s+1)*CW-1:0]   lo;
        if (s == 0) begin : g_src
            assign ua = a_q;
            assign ub = b_q;
            assign c  = c_q;
            assign v  = v_q;
            assign lo = part[CW-1:0];
        end else begin : g_src
            assign ua = g_st[s-1].g_reg.ua_q;
            assign ub = g_st[s-1].g_reg.ub_q;
            assign c  = g_st[s-1].g_reg.c_r;
            assign v  = g_st[s-1].g_reg.v_r;
            assign lo = {part[CW-1:0], g_st[s-1].g_reg.lo_q};
        end
        assign part = {1'b0, ua[CW-1:0]} + {1'b0, ub[CW-1:0]} + {{CW{1'b0}}, c};
        if (s < STAGES - 1) begin : g_reg
            logic [HW-CW-1:0]    ua_q, ub_q;
            logic [(s+1)*CW-1:0] lo_q;
            logic                c_r, v_r;
            always_ff @(posedge clk) begin
                if (!rst_n) v_r <= 1'b0;
                else if (!stall) v_r <= v;
            end
            always_ff @(posedge clk) begin
                if (!stall) begin
                    ua_q <= ua[HW-1:CW];
                    ub_q <= ub[HW-1:CW];
                    lo_q <= lo;
                    c_r  <= part[CW];
                end
            end
        end else begin : g_out
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    out_valid <= 1'b0;
                    sum       <= '0;
                    cout      <= 1'b0;
`ifdef PIPE_ADDER_OVF_EN
                    ovf       <= 1'b0;
`endif
                end else if (!stall) begin
                    out_valid <= v;
                    sum       <= lo;
                    cout      <= part[CW];
`ifdef PIPE_ADDER_OVF_EN
                    // ua/ub here hold the top chunk, so bit CW-1 is the operand MSB.
                    ovf       <= (ua[CW-1] == ub[CW-1]) && (part[CW-1] != ua[CW-1]);
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_carry_adder.sv
// tb_pipelined_carry_adder: directed and random checks of pipelined_carry_adder against an arithmetic reference queue.
module tb_pipelined_carry_adder;
    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             cin = 1'b0;
    logic             sub = 1'b0;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             in_ready, out_valid, cout;
    logic [WIDTH-1:0] sum;
`ifdef PIPE_ADDER_OVF_EN
    logic             ovf;
    logic             seen_ovf = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int acc_cycle = 0;
    bit live = 0;
    bit last_acc = 0;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
        int               age;
    } ent_t;
    ent_t q[$];

    pipelined_carry_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef PIPE_ADDER_OVF_EN
       ,.ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Plain integer arithmetic: add = a+b+cin, subtract = a-b with borrow shown as cout=0.
    function automatic ent_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic ci, input logic sb);
        ent_t e;
        int   r, sr;
        r  = sb ? (int'(x) + 65536 - int'(y)) : (int'(x) + int'(y) + int'(ci));
        sr = sb ? (int'($signed(x)) - int'($signed(y)))
                : (int'($signed(x)) + int'($signed(y)) + int'(ci));
        e.s   = r[WIDTH-1:0];
        e.c   = r[WIDTH];
        e.o   = (sr > 32767) || (sr < -32768);
        e.age = 0;
        return e;
    endfunction

    // One clock: check outputs against the queue head, then advance the model on the edge.
    task automatic cyc();
        bit exp_v, st, acc, xfer;
        #1;
        exp_v = (q.size() > 0) && (q[0].age >= STAGES);
        st    = exp_v && !out_ready;
        acc   = in_valid && !st;
        xfer  = exp_v && out_ready;
        if (live) begin
            chk("out_valid", out_valid, exp_v);
            chk("in_ready", in_ready, !st);
            if (exp_v) begin
                chk("sum", sum, q[0].s);
                chk("cout", cout, q[0].c);
`ifdef PIPE_ADDER_OVF_EN
                chk("ovf", ovf, q[0].o);
`endif
            end
        end
        @(posedge clk);
        live = 1;
        cycle++;
        last_acc = 0;
        if (!rst_n) q.delete();
        else begin
            if (!st) foreach (q[k]) q[k].age = q[k].age + 1;
            if (xfer) void'(q.pop_front());
            if (acc) begin
                q.push_back(model(a, b, cin, sub));
                last_acc  = 1;
                acc_cycle = cycle;
            end
        end
        #1;
    endtask

    task automatic one(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic ci, input logic sb, input logic [WIDTH-1:0] es, input logic ec);
        int n = 0;
        a = x; b = y; cin = ci; sub = sb; in_valid = 1; out_ready = 1;
        cyc();
        in_valid = 0;
        while (!out_valid && n < 20) begin
            cyc();
            n++;
        end
        chk({tag, "_latency"}, cycle - acc_cycle, STAGES);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
`ifdef PIPE_ADDER_OVF_EN
        seen_ovf = ovf;
`endif
        cyc();
        chk({tag, "_one_cycle"}, out_valid, 0);
    endtask

    initial begin
        int i, n, rx, st_cnt;
        repeat (2) cyc();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
`ifdef PIPE_ADDER_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        rst_n = 1;
        cyc();

        one("add", 16'h0003, 16'h0005, 1'b0, 1'b0, 16'h0008, 1'b0);
        one("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
        one("cin", 16'h000F, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0);
        one("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0);
        one("sub", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);

        i = 0; n = 0; rx = 0; st_cnt = 0;
        while ((i < 8 || q.size() > 0) && n < 100) begin
            a = 16'(i); b = 16'h0100; cin = 0; sub = 0;
            in_valid  = (i < 8);
            out_ready = !(out_valid && st_cnt < 3);
            if (!out_ready) st_cnt++;
            if (out_valid && out_ready) begin
                chk("bp_order", sum, 16'h0100 + 16'(rx));
                rx++;
            end
            cyc();
            n++;
            if (last_acc) i++;
        end
        in_valid = 0; out_ready = 1;
        chk("bp_count", rx, 8);
        chk("bp_stalls", st_cnt, 3);

        repeat (300) begin
            a = 16'($urandom); b = 16'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            cyc();
        end
        in_valid = 0; out_ready = 1;
        repeat (STAGES + 4) cyc();
        chk("rand_drain", q.size(), 0);

        in_valid = 1; sub = 0; cin = 0; b = 16'h0010;
        for (int k = 0; k < 3; k++) begin
            a = 16'(k + 1);
            cyc();
        end
        rst_n = 0;
        cyc();
        rst_n = 1; in_valid = 0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_cout", cout, 0);
        repeat (8) cyc();
        one("fresh", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0);

`ifdef PIPE_ADDER_OVF_EN
        one("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0);
        chk("ovf_add_flag", seen_ovf, 1);
        one("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1);
        chk("ovf_sub_flag", seen_ovf, 1);
        one("ovf_none", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0);
        chk("ovf_none_flag", seen_ovf, 0);
`endif

        repeat (STAGES + 2) cyc();
        chk("final_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
